// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state encoding, reset defaults and width helper
// for the serial pattern detector family.
package seq_det_pkg;
    typedef enum logic {RUN = 1'b0, DIS = 1'b1} state_e;
    localparam logic [7:0] DEF_PATTERN = 8'b0000_1011;
    localparam int DEF_LEN = 4;
    localparam bit DEF_OVERLAP = 1'b0;
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction
endpackage

// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: serial data, configuration and result signals of
// the parametrised detector.
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W = 8
);
    import seq_det_pkg::*;
    localparam int LEN_W = len_w(MAX_LEN);
    logic x;
    logic x_valid;
    logic cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic cfg_overlap;
    logic clr_count;
    logic y;
    logic [CNT_W-1:0] match_count;
    logic cfg_err;
    modport master (
        output x, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
        input y, match_count, cfg_err
    );
    modport slave (
        input x, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
        output y, match_count, cfg_err
    );
endinterface

// File: rtl/seq_det_sat_counter.sv
// seq_det_sat_counter: W-bit saturating up-counter; clr wins over inc.
module seq_det_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign count = cnt_q;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-configurable serial pattern detector with
// overlap control, bit qualifier, saturating match count and config error.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(seq_det_pkg::DEF_PATTERN),
    parameter int DEF_LEN = seq_det_pkg::DEF_LEN,
    parameter bit DEF_OVERLAP = seq_det_pkg::DEF_OVERLAP
) (
    input logic clk,
    input logic reset_n,
    seq_detector_param_if.slave s
);
    import seq_det_pkg::*;
    localparam int LEN_W = len_w(MAX_LEN);
    state_e state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d, pat_q, pat_d, hist_n, mask;
    logic [LEN_W-1:0] len_q, len_d, fill_q, fill_d, fill_n;
    logic ovl_q, ovl_d, y_q, y_d, err_q, err_d;
    logic legal, load_ok, accept, match;
    always_comb begin
        legal = s.cfg_len != '0 && s.cfg_len <= LEN_W'(MAX_LEN);
        load_ok = s.cfg_load && legal;
        accept = s.x_valid && state_q == RUN && !s.cfg_load;
        hist_n = {hist_q[MAX_LEN-2:0], s.x};
        fill_n = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
        // Only the low len bits of history take part in the compare.
        mask = {MAX_LEN{1'b1}} >> (LEN_W'(MAX_LEN) - len_q);
        match = accept && fill_n >= len_q && ((hist_n ^ pat_q) & mask) == '0;
        state_d = s.cfg_load ? (legal ? RUN : DIS) : state_q;
        err_d = err_q | (s.cfg_load & ~legal);
        pat_d = load_ok ? s.cfg_pattern : pat_q;
        len_d = load_ok ? s.cfg_len : len_q;
        ovl_d = load_ok ? s.cfg_overlap : ovl_q;
        hist_d = load_ok ? '0 : accept ? hist_n : hist_q;
        fill_d = load_ok ? '0 : !accept ? fill_q : (match && !ovl_q) ? '0 : fill_n;
        y_d = match;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= RUN;
            hist_q <= '0;
            fill_q <= '0;
            pat_q <= DEF_PATTERN;
            len_q <= LEN_W'(DEF_LEN);
            ovl_q <= DEF_OVERLAP;
            y_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q <= pat_d;
            len_q <= len_d;
            ovl_q <= ovl_d;
            y_q <= y_d;
            err_q <= err_d;
        end
    seq_det_sat_counter #(.W(CNT_W)) u_cnt (
        .clk(clk),
        .reset_n(reset_n),
        .inc(match),
        .clr(s.clr_count),
        .count(s.match_count)
    );
    assign s.y = y_q;
    assign s.cfg_err = err_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: scoreboard bench driving an 8-bit-count and a
// 2-bit-count detector with the same stimulus against a bit-list model.
module tb_seq_detector_param;
    localparam int ML = 8;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n, x, x_valid, cfg_load, cfg_overlap, clr_count;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    seq_detector_param_if #(.MAX_LEN(ML), .CNT_W(8)) ifa ();
    seq_detector_param_if #(.MAX_LEN(ML), .CNT_W(2)) ifb ();
    assign ifa.x = x;
    assign ifa.x_valid = x_valid;
    assign ifa.cfg_load = cfg_load;
    assign ifa.cfg_pattern = cfg_pattern;
    assign ifa.cfg_len = cfg_len;
    assign ifa.cfg_overlap = cfg_overlap;
    assign ifa.clr_count = clr_count;
    assign ifb.x = x;
    assign ifb.x_valid = x_valid;
    assign ifb.cfg_load = cfg_load;
    assign ifb.cfg_pattern = cfg_pattern;
    assign ifb.cfg_len = cfg_len;
    assign ifb.cfg_overlap = cfg_overlap;
    assign ifb.clr_count = clr_count;
    seq_detector_param #(.MAX_LEN(ML), .CNT_W(8)) dut_a (.clk(clk), .reset_n(reset_n), .s(ifa));
    seq_detector_param #(.MAX_LEN(ML), .CNT_W(2)) dut_b (.clk(clk), .reset_n(reset_n), .s(ifb));

    typedef struct packed {
        logic y;
        logic [7:0] ca;
        logic [1:0] cb;
        logic err;
    } exp_t;
    exp_t sb[$];
    int n_vec = 0;
    int n_mis = 0;

    // Model: list of accepted bits since the last clear, newest at the back.
    logic [7:0] m_pat;
    int m_len, m_ca, m_cb;
    bit m_ovl, m_en, m_err;
    bit m_bits[$];

    task automatic model_reset();
        m_pat = 8'b0000_1011;
        m_len = 4;
        m_ovl = 1'b0;
        m_en = 1'b1;
        m_err = 1'b0;
        m_bits.delete();
        m_ca = 0;
        m_cb = 0;
    endtask

    task automatic tick();
        bit hit;
        hit = 1'b0;
        if (cfg_load) begin
            if (cfg_len >= 1 && cfg_len <= ML) begin
                m_pat = cfg_pattern;
                m_len = int'(cfg_len);
                m_ovl = cfg_overlap;
                m_en = 1'b1;
                m_bits.delete();
            end else begin
                m_en = 1'b0;
                m_err = 1'b1;
            end
        end else if (x_valid && m_en) begin
            m_bits.push_back(x);
            if (m_bits.size() > ML) void'(m_bits.pop_front());
            if (m_bits.size() >= m_len) begin
                hit = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 1'b0;
            end
            if (hit && !m_ovl) m_bits.delete();
        end
        m_ca = clr_count ? 0 : (hit && m_ca < 255) ? m_ca + 1 : m_ca;
        m_cb = clr_count ? 0 : (hit && m_cb < 3) ? m_cb + 1 : m_cb;
        sb.push_back('{hit, 8'(m_ca), 2'(m_cb), m_err});
        @(negedge clk);
        #1;
    endtask

    task automatic bit_in(input bit b, input bit clr = 1'b0);
        cfg_load = 1'b0;
        x_valid = 1'b1;
        x = b;
        clr_count = clr;
        tick();
    endtask

    task automatic gap(input int n);
        cfg_load = 1'b0;
        x_valid = 1'b0;
        clr_count = 1'b0;
        repeat (n) tick();
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
        cfg_load = 1'b1;
        cfg_pattern = p;
        cfg_len = l;
        cfg_overlap = o;
        x_valid = 1'b1;
        x = 1'($urandom_range(0, 1));
        clr_count = 1'b0;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        sb.push_back('{1'b0, 8'd0, 2'd0, 1'b0});
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic stream(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_vec++;
            if ({ifa.y, ifa.match_count, ifb.match_count, ifa.cfg_err} !== e ||
                ifb.y !== e.y || ifb.cfg_err !== e.err) begin
                n_mis++;
                $display("FAIL vec %0d @%0t: got y=%b/%b cnt=%0d/%0d err=%b/%b, want y=%b cnt=%0d/%0d err=%b",
                         n_vec, $time, ifa.y, ifb.y, ifa.match_count, ifb.match_count,
                         ifa.cfg_err, ifb.cfg_err, e.y, e.ca, e.cb, e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        logic [3:0] l;
        reset_n = 1'b1;
        x = 1'b0;
        x_valid = 1'b0;
        cfg_load = 1'b0;
        cfg_pattern = '0;
        cfg_len = '0;
        cfg_overlap = 1'b0;
        clr_count = 1'b0;
        #1;
        do_reset();
        stream(16'b101_1011, 7);
        load(8'b1011, 4'd4, 1'b1);
        stream(16'b101_1011, 7);
        load(8'b110, 4'd3, 1'b0);
        bit_in(1'b1);
        gap(2);
        bit_in(1'b1);
        gap(2);
        bit_in(1'b0);
        gap(2);
        load(8'b1011, 4'd0, 1'b0);
        stream(16'b1011, 4);
        load(8'b1011, 4'd12, 1'b0);
        stream(16'b1011, 4);
        load(8'b1011, 4'd4, 1'b0);
        stream(16'b1011, 4);
        load(8'b1, 4'd1, 1'b1);
        bit_in(1'b0, 1'b1);
        repeat (5) bit_in(1'b1);
        bit_in(1'b1, 1'b1);
        load(8'b1010_0110, 4'd8, 1'b1);
        stream(16'b1010_0110_1010_0110, 16);
        do_reset();
        stream(16'b101, 3);
        do_reset();
        bit_in(1'b1);
        stream(16'b1011, 4);
        for (int c = 0; c < 2000; c++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 499) == 0) do_reset();
            else if (r < 3) begin
                if ($urandom_range(0, 7) == 0)
                    l = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
                else
                    l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(1, 3));
                load(8'($urandom), l, 1'($urandom_range(0, 1)));
            end else begin
                cfg_load = 1'b0;
                x_valid = $urandom_range(0, 3) != 0;
                x = 1'($urandom_range(0, 1));
                clr_count = $urandom_range(0, 29) == 0;
                tick();
            end
        end
        gap(1);
        @(negedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised, runtime-configurable serial bit-pattern detector; the next generation of the fixed 1011 Moore detectors.
- Detects any pattern of 1..MAX_LEN bits in overlapping or non-overlapping mode.
- Adds a bit-valid qualifier, a saturating match counter and configuration-error reporting.
- Sits on a serial data path; its `y` pulse feeds downstream framing/alarm logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (must be >= 2).
- CNT_W, 8, match counter width.
- DEF_PATTERN, 8'b0000_1011, pattern loaded at reset (LSB-aligned).
- DEF_LEN, 4, pattern length loaded at reset.
- DEF_OVERLAP, 0, overlap mode loaded at reset (0 = non-overlapping).

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled only when high.
- cfg_load  in  1  single-cycle strobe; latches the three cfg_* inputs.
- cfg_pattern  in  MAX_LEN  pattern bits; bit cfg_len-1 is the first bit received, bit 0 the last.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- clr_count  in  1  synchronous clear of match_count.
- y  out  1  registered match pulse (Moore-style).
- match_count  out  CNT_W  saturating count of matches.
- cfg_err  out  1  sticky; set by an illegal cfg_load.

Behaviour:
- Reset (reset_n low, asynchronous):
  - pattern/len/overlap registers take DEF_*.
  - history = 0, fill = 0, state = RUN.
  - y = 0, match_count = 0, cfg_err = 0.
  - Reset is honoured at any time, including mid-pattern; partial history is discarded.
- Registers:
  - hist[MAX_LEN-1:0] is a shift register.
  - fill counts accepted bits since the last clear; it saturates at MAX_LEN.
- States:
  - RUN: detector active.
  - DIS: detector disabled after an illegal configuration. In DIS, x is ignored, y = 0 and match_count holds.
- Accepted bit (x_valid = 1, state RUN, no cfg_load):
  - hist_nxt = {hist[MAX_LEN-2:0], x}; fill_nxt = min(fill+1, MAX_LEN).
  - match = (fill_nxt >= len) and (hist_nxt[len-1:0] == pattern[len-1:0]).
- Latency: y is registered.
  - It rises after the same clk edge that samples the final pattern bit and is high for exactly one cycle per match.
  - This timing is identical to a Moore detector reaching its accept state.
- On match:
  - Non-overlapping: fill <= 0, so no bit of a matched pattern is reused.
  - Overlapping: fill is kept, so suffix reuse is allowed.
- x_valid = 0: hist, fill and count hold; y <= 0. Gaps between valid bits are transparent to matching.
- cfg_load:
  - Legal (1 <= cfg_len <= MAX_LEN): latch pattern, len and overlap; hist <= 0; fill <= 0; y <= 0; state <= RUN. cfg_err is unchanged.
  - Illegal (cfg_len == 0 or > MAX_LEN): keep the old configuration; state <= DIS; cfg_err <= 1.
  - A later legal cfg_load returns the block to RUN. cfg_err is cleared only by reset.
  - cfg_load takes priority over x_valid in the same cycle; that bit is dropped.
- match_count:
  - Increments on each match and saturates at 2^CNT_W-1, with no wrap.
  - clr_count takes priority: match and clr_count in the same cycle gives count 0, while y still pulses.
- Length-1 pattern, overlap mode: y pulses on every accepted bit equal to pattern[0].

Decomposition:
- Shared package seq_det_pkg holds:
  - The state encoding (RUN, DIS).
  - DEF_PATTERN, DEF_LEN and DEF_OVERLAP defaults.
  - A LEN_W = $clog2(MAX_LEN+1) helper.
- One sub-module, seq_det_sat_counter: a CNT_W saturating counter with inc and clr, clr having priority. It is reusable by the other detectors.

Test Plan:
- Reset defaults, non-overlap: x stream 1,0,1,1,0,1,1 -> y pulses once, after the 4th bit; match_count = 1.
- Same stream after cfg_load (pattern 1011, len 4, overlap 1) -> y pulses after the 4th and 7th bits; match_count = 2.
- cfg_load pattern 3'b110, len 3, non-overlap; stream 1,1,0 with x_valid low for 2 cycles between each bit -> one y pulse, after the final 0; y low during gaps.
- cfg_load with cfg_len = 0 -> cfg_err = 1, y stays 0 on stream 1,0,1,1; then a legal cfg_load -> detection resumes, cfg_err stays 1.
- CNT_W = 2, pattern 1, len 1, overlap 1; five 1s -> count 1,2,3,3,3; clr_count together with a 6th 1 -> count 0, y = 1.
- Pull reset_n low after bits 1,0,1 of 1011, release, then send 1 -> no y; a full 1,0,1,1 afterwards -> y pulses once.
